pwm_generator: RTL and testbench

//   Consumes the five control registers written over SPI (output enables, PWM-mode enables, duty cycle).

---
 rtl/pwm_generator_if.sv | 31 +++
 rtl/pwm_generator.sv | 93 +++++++++
 tb/tb_pwm_generator.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_generator_if.sv
// Control-register and pin-drive bundle between the SPI register file and the PWM generator.
// master = register-file side, slave = PWM generator side.
interface pwm_generator_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out,
    input  period_start
  );

  modport slave (
    input  en_reg_out_7_0,
    input  en_reg_out_15_8,
    input  en_reg_pwm_7_0,
    input  en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out,
    output period_start
  );
endinterface

// File: rtl/pwm_generator.sv
// 16-pin PWM driver: each pin is off, static high, or follows one shared PWM waveform.
// Duty is double-buffered and only changes at a period boundary.
module pwm_generator #(
  parameter int unsigned CLK_DIV = 3000  // clk cycles per counter tick, 1..65535
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_generator_if.slave  bus
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] prescaler, prescaler_nxt;
  logic [7:0]  counter, counter_nxt;
  logic [7:0]  duty_active, duty_nxt;
  logic        period_start_nxt;
  logic [15:0] out_nxt;

  logic        tick;
  logic        pwm_level;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign tick   = (prescaler == DIV_LAST);
  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  // Duty 255 is special-cased so a full-on pin never drops for the counter==255 tick.
  assign pwm_level = (duty_active == 8'hFF) ? 1'b1 : (counter < duty_active);

  // ST_LOAD is the single cycle after reset release: it loads the shadow duty and
  // flags a period start while holding the prescaler, so the first period is full length.
  always_comb begin
    state_nxt        = ST_RUN;
    prescaler_nxt    = prescaler;
    counter_nxt      = counter;
    duty_nxt         = duty_active;
    period_start_nxt = 1'b0;
    unique case (state)
      ST_LOAD: begin
        prescaler_nxt    = '0;
        counter_nxt      = '0;
        duty_nxt         = bus.pwm_duty_cycle;
        period_start_nxt = 1'b1;
      end
      ST_RUN: begin
        prescaler_nxt = tick ? '0 : prescaler + 16'd1;
        if (tick) begin
          counter_nxt = counter + 8'd1;
          if (counter == 8'hFF) begin
            duty_nxt         = bus.pwm_duty_cycle;
            period_start_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_LOAD;
      end
    endcase
  end

  always_comb begin
    out_nxt = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      out_nxt[i] = en_out[i] & (en_pwm[i] ? pwm_level : 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_LOAD;
      prescaler        <= '0;
      counter          <= '0;
      duty_active      <= '0;
      bus.out          <= '0;
      bus.period_start <= 1'b0;
    end else begin
      state            <= state_nxt;
      prescaler        <= prescaler_nxt;
      counter          <= counter_nxt;
      duty_active      <= duty_nxt;
      bus.out          <= out_nxt;
      bus.period_start <= period_start_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator with CLK_DIV = 4 (1024-clk period); a cycle model
// pushes expected pin/period_start values that are popped and checked every clk.
module tb_pwm_generator;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pwm_generator_if bus();

  pwm_generator #(.CLK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] out;
    logic        ps;
  } exp_t;

  exp_t q[$];

  // Reference model indexed by edges since reset release: edge 1 loads duty,
  // counter after edge k is ((k-1)/4) mod 256, and every 1024 edges a new period starts.
  int          k;
  logic [7:0]  cp;
  logic [7:0]  dp;
  logic [15:0] m_en_o;
  logic [15:0] m_en_p;
  logic        m_lvl;
  exp_t        m_e;

  always @(posedge clk) begin
    if (!rst_n) begin
      k   = 0;
      cp  = 8'd0;
      dp  = 8'd0;
      m_e = '0;
    end else begin
      k++;
      m_en_o = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
      m_en_p = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
      m_lvl  = (dp == 8'hFF) ? 1'b1 : (cp < dp);
      for (int i = 0; i < 16; i++) begin
        m_e.out[i] = m_en_o[i] ? (m_en_p[i] ? m_lvl : 1'b1) : 1'b0;
      end
      m_e.ps = (((k - 1) % 1024) == 0);
      if (m_e.ps) dp = bus.pwm_duty_cycle;
      cp = 8'(((k - 1) / 4) % 256);
    end
    q.push_back(m_e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      assert (bus.out === e.out) else begin
        failures++;
        $error("FAIL cycle_out observed=%h expected=%h at %0t", bus.out, e.out, $time);
      end
      checks++;
      assert (bus.period_start === e.ps) else begin
        failures++;
        $error("FAIL cycle_period_start observed=%b expected=%b at %0t", bus.period_start, e.ps, $time);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic wait_ps(input bit fresh);
    int n = 0;
    if (fresh) @(negedge clk);
    while (bus.period_start !== 1'b1 && n < 2100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (bus.period_start === 1'b1) else begin
      failures++;
      $error("FAIL wait_period_start observed=%b expected=1 (timeout)", bus.period_start);
    end
  endtask

  // Samples one pin for the 1024 clks following a period_start; optionally rewrites
  // the requested duty after sample chg_at.
  task automatic count_bit(input int idx, input int chg_at, input logic [7:0] chg_val,
                           output int hi, output logic first);
    hi    = 0;
    first = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (i == 0) first = bus.out[idx];
      if (bus.out[idx] === 1'b1) hi++;
      if (i == chg_at) begin
        #1 bus.pwm_duty_cycle = chg_val;
      end
    end
  endtask

  initial begin
    int   hi;
    logic first;
    checks   = 0;
    failures = 0;

    // 1: static-high pin 0
    rst_n                = 1'b0;
    bus.en_reg_out_7_0   = 8'h01;
    bus.en_reg_out_15_8  = 8'h00;
    bus.en_reg_pwm_7_0   = 8'h00;
    bus.en_reg_pwm_15_8  = 8'h00;
    bus.pwm_duty_cycle   = 8'd128;
    repeat (3) @(negedge clk);
    chk("t1_out_in_reset", 32'(bus.out), 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t1_first_period_start", 32'(bus.period_start), 32'd1);
    chk("t1_static_first", 32'(bus.out), 32'h0001);
    repeat (4) begin
      @(negedge clk);
      chk("t1_static", 32'(bus.out), 32'h0001);
    end

    // 2: 50 % duty on pin 0
    #1 bus.en_reg_pwm_7_0 = 8'h01;
    wait_ps(1'b1);
    chk("t2_low_at_period_start", 32'(bus.out[0]), 32'd0);
    count_bit(0, -1, 8'd0, hi, first);
    chk("t2_rise_after_period_start", 32'(first), 32'd1);
    chk("t2_high_clks", 32'(hi), 32'd512);
    count_bit(0, -1, 8'd0, hi, first);
    chk("t2_high_clks_next", 32'(hi), 32'd512);

    // 3: duty 0 then 255
    #1 bus.pwm_duty_cycle = 8'd0;
    wait_ps(1'b1);
    count_bit(0, 500, 8'd255, hi, first);
    chk("t3_duty0_high_clks", 32'(hi), 32'd0);
    chk("t3_boundary", 32'(bus.period_start), 32'd1);
    count_bit(0, -1, 8'd0, hi, first);
    chk("t3_duty255_high_clks", 32'(hi), 32'd1024);

    // 4: mid-period duty change takes effect only at the next period
    #1 bus.pwm_duty_cycle = 8'd64;
    wait_ps(1'b1);
    count_bit(0, 400, 8'd192, hi, first);
    chk("t4_current_period_high", 32'(hi), 32'd256);
    chk("t4_boundary", 32'(bus.period_start), 32'd1);
    count_bit(0, -1, 8'd0, hi, first);
    chk("t4_next_period_high", 32'(hi), 32'd768);

    // 5: all pins enabled, odd pins PWM
    #1;
    bus.en_reg_out_7_0  = 8'hFF;
    bus.en_reg_out_15_8 = 8'hFF;
    bus.en_reg_pwm_7_0  = 8'hAA;
    bus.en_reg_pwm_15_8 = 8'hAA;
    bus.pwm_duty_cycle  = 8'd64;
    wait_ps(1'b1);
    count_bit(1, -1, 8'd0, hi, first);
    chk("t5_odd_pin_high", 32'(hi), 32'd256);
    chk("t5_even_pins_static", 32'(bus.out & 16'h5555), 32'h5555);
    #1 bus.en_reg_out_15_8 = 8'h00;
    @(negedge clk);
    chk("t5_upper_disabled", 32'(bus.out[15:8]), 32'h0);
    chk("t5_lower_even_kept", 32'(bus.out[7:0] & 8'h55), 32'h55);

    // 6: reset mid-period
    repeat (300) @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_out_in_reset", 32'(bus.out), 32'h0);
      chk("t6_ps_in_reset", 32'(bus.period_start), 32'd0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ps_after_release", 32'(bus.period_start), 32'd1);
    chk("t6_out_after_release", 32'(bus.out), 32'h0055);
    count_bit(1, -1, 8'd0, hi, first);
    chk("t6_restart_high", 32'(hi), 32'd256);
    chk("t6_next_boundary", 32'(bus.period_start), 32'd1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
